// File: rtl/sifreleme_denetleyici_pkg.sv
// rtl/sifreleme_denetleyici_pkg.sv - operation codes, FSM encoding and response record
package sifreleme_denetleyici_pkg;

    localparam logic [2:0] SIFRELEME_HMDST = 3'd0;
    localparam logic [2:0] SIFRELEME_PKG   = 3'd1;
    localparam logic [2:0] SIFRELEME_RVRS  = 3'd2;
    localparam logic [2:0] SIFRELEME_SLADD = 3'd3;
    localparam logic [2:0] SIFRELEME_CNTZ  = 3'd4;
    localparam logic [2:0] SIFRELEME_CNTP  = 3'd5;

    typedef enum logic {
        SIFDEN_BOS     = 1'b0,
        SIFDEN_HESAPLA = 1'b1
    } sifden_durum_t;

    localparam int SIFDEN_FIFO_DERINLIK = 2;

    typedef struct packed {
        logic [31:0] sonuc;
        logic [4:0]  hedef;
        logic        hata;
    } yanit_t;

    function automatic logic kod_gecersiz(input logic [2:0] kod);
        case (kod)
            SIFRELEME_HMDST, SIFRELEME_PKG, SIFRELEME_RVRS,
            SIFRELEME_SLADD, SIFRELEME_CNTZ, SIFRELEME_CNTP: return 1'b0;
            default:                                         return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sifreleme_denetleyici_yanit_fifo.sv
// rtl/sifreleme_denetleyici_yanit_fifo.sv - 2-entry response buffer with push, pop and clear
module yanit_fifo
    import sifreleme_denetleyici_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  yanit_t     veri,
    output yanit_t     bas,
    output logic [1:0] sayi
);

    yanit_t     mem [SIFDEN_FIFO_DERINLIK];
    logic       yaz_ptr;
    logic       oku_ptr;
    logic       push_ok;
    logic       pop_ok;

    assign pop_ok  = pop && (sayi != 2'd0);
    assign push_ok = push && ((sayi < 2'(SIFDEN_FIFO_DERINLIK)) || pop_ok);
    assign bas     = mem[oku_ptr];

    // Clear only rewinds the pointers; stale contents stay hidden behind sayi == 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sayi    <= 2'd0;
            yaz_ptr <= 1'b0;
            oku_ptr <= 1'b0;
            for (int i = 0; i < SIFDEN_FIFO_DERINLIK; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            sayi    <= 2'd0;
            yaz_ptr <= 1'b0;
            oku_ptr <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[yaz_ptr] <= veri;
                yaz_ptr      <= ~yaz_ptr;
            end
            if (pop_ok) begin
                oku_ptr <= ~oku_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   sayi <= sayi + 2'd1;
                2'b01:   sayi <= sayi - 2'd1;
                default: sayi <= sayi;
            endcase
        end
    end

endmodule

// File: rtl/sifreleme_denetleyici.sv
// rtl/sifreleme_denetleyici.sv - issue/response controller for the encryption bit-manipulation unit
module sifreleme_denetleyici
    import sifreleme_denetleyici_pkg::*;
#(
    parameter int ISLEM_GECIKMESI = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        istek_gecerli_i,
    output logic        istek_hazir_o,
    input  logic [2:0]  istek_kontrol_i,
    input  logic [31:0] istek_deger1_i,
    input  logic [31:0] istek_deger2_i,
    input  logic [4:0]  istek_hedef_i,
    output logic [2:0]  birim_kontrol_o,
    output logic [31:0] birim_deger1_o,
    output logic [31:0] birim_deger2_o,
    input  logic [31:0] birim_sonuc_i,
    output logic        yanit_gecerli_o,
    input  logic        yanit_hazir_i,
    output logic [31:0] yanit_sonuc_o,
    output logic [4:0]  yanit_hedef_o,
    output logic        yanit_hata_o,
    input  logic        temizle_i,
    output logic        durdur_o
);

    sifden_durum_t durum, durum_sonraki;
    logic [3:0]    sayac, sayac_sonraki;
    logic [4:0]    hedef_q;
    logic          hata_q;
    logic          kabul;
    logic          push;
    logic          pop;
    logic [1:0]    sayi;
    yanit_t        yeni;
    yanit_t        bas;

    // Ready never looks at yanit_hazir_i, so the stall path stays short.
    assign istek_hazir_o   = (durum == SIFDEN_BOS) && (sayi < 2'(SIFDEN_FIFO_DERINLIK));
    assign kabul           = istek_gecerli_i && istek_hazir_o && !temizle_i;
    assign durdur_o        = istek_gecerli_i && !istek_hazir_o;
    assign yanit_gecerli_o = (sayi != 2'd0);
    assign pop             = yanit_gecerli_o && yanit_hazir_i;

    always_comb begin
        durum_sonraki = durum;
        sayac_sonraki = sayac;
        push          = 1'b0;
        case (durum)
            SIFDEN_BOS: begin
                if (kabul) begin
                    durum_sonraki = SIFDEN_HESAPLA;
                    sayac_sonraki = 4'(ISLEM_GECIKMESI);
                end
            end
            SIFDEN_HESAPLA: begin
                if (sayac == 4'd1) begin
                    push          = !temizle_i;
                    durum_sonraki = SIFDEN_BOS;
                    sayac_sonraki = 4'd0;
                end else begin
                    sayac_sonraki = sayac - 4'd1;
                end
            end
            default: begin
                durum_sonraki = SIFDEN_BOS;
                sayac_sonraki = 4'd0;
            end
        endcase
        if (temizle_i) begin
            durum_sonraki = SIFDEN_BOS;
            sayac_sonraki = 4'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum <= SIFDEN_BOS;
            sayac <= 4'd0;
        end else begin
            durum <= durum_sonraki;
            sayac <= sayac_sonraki;
        end
    end

    // Operand registers hold across a flush; the unit just keeps computing on them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            birim_kontrol_o <= 3'd0;
            birim_deger1_o  <= 32'd0;
            birim_deger2_o  <= 32'd0;
            hedef_q         <= 5'd0;
            hata_q          <= 1'b0;
        end else if (kabul) begin
            birim_kontrol_o <= istek_kontrol_i;
            birim_deger1_o  <= istek_deger1_i;
            birim_deger2_o  <= istek_deger2_i;
            hedef_q         <= istek_hedef_i;
            hata_q          <= kod_gecersiz(istek_kontrol_i);
        end
    end

    assign yeni = '{sonuc: birim_sonuc_i, hedef: hedef_q, hata: hata_q};

    yanit_fifo u_yanit_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .pop   (pop),
        .clear (temizle_i),
        .veri  (yeni),
        .bas   (bas),
        .sayi  (sayi)
    );

    assign yanit_sonuc_o = bas.sonuc;
    assign yanit_hedef_o = bas.hedef;
    assign yanit_hata_o  = bas.hata;

endmodule

// File: tb/tb_sifreleme_denetleyici.sv
// tb/tb_sifreleme_denetleyici.sv - directed vector bench for sifreleme_denetleyici
module tb_sifreleme_denetleyici;
    import sifreleme_denetleyici_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance a: ISLEM_GECIKMESI = 1, instance b: ISLEM_GECIKMESI = 4
    logic        rst_n_a, gecerli_a, yhazir_a, temizle_a;
    logic [2:0]  kod_a;
    logic [31:0] d1_a, d2_a;
    logic [4:0]  hedef_a;
    logic        hazir_a, ygec_a, yhata_a, durdur_a;
    logic [2:0]  bk_a;
    logic [31:0] bd1_a, bd2_a, bsonuc_a, ysonuc_a;
    logic [4:0]  yhedef_a;

    logic        rst_n_b, gecerli_b, yhazir_b, temizle_b;
    logic [2:0]  kod_b;
    logic [31:0] d1_b, d2_b;
    logic [4:0]  hedef_b;
    logic        hazir_b, ygec_b, yhata_b, durdur_b;
    logic [2:0]  bk_b;
    logic [31:0] bd1_b, bd2_b, bsonuc_b, ysonuc_b;
    logic [4:0]  yhedef_b;

    function automatic logic [31:0] birim(input logic [2:0] k, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        int          n;
        logic        bulundu;
        r = 32'd0;
        case (k)
            SIFRELEME_HMDST: r = 32'($countones(x ^ y));
            SIFRELEME_PKG:   r = {y[15:0], x[15:0]};
            SIFRELEME_RVRS:  for (int i = 0; i < 32; i++) r[i] = x[31-i];
            SIFRELEME_SLADD: r = (x << 1) + y;
            SIFRELEME_CNTZ: begin
                n = 0;
                bulundu = 1'b0;
                for (int i = 0; i < 32; i++) begin
                    if (!bulundu) begin
                        if (x[i]) bulundu = 1'b1;
                        else n++;
                    end
                end
                r = 32'(n);
            end
            SIFRELEME_CNTP:  r = 32'($countones(x));
            default:         r = 32'd0;
        endcase
        return r;
    endfunction

    assign bsonuc_a = birim(bk_a, bd1_a, bd2_a);
    assign bsonuc_b = birim(bk_b, bd1_b, bd2_b);

    sifreleme_denetleyici #(.ISLEM_GECIKMESI(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n_a), .istek_gecerli_i(gecerli_a), .istek_hazir_o(hazir_a),
        .istek_kontrol_i(kod_a), .istek_deger1_i(d1_a), .istek_deger2_i(d2_a), .istek_hedef_i(hedef_a),
        .birim_kontrol_o(bk_a), .birim_deger1_o(bd1_a), .birim_deger2_o(bd2_a), .birim_sonuc_i(bsonuc_a),
        .yanit_gecerli_o(ygec_a), .yanit_hazir_i(yhazir_a), .yanit_sonuc_o(ysonuc_a),
        .yanit_hedef_o(yhedef_a), .yanit_hata_o(yhata_a), .temizle_i(temizle_a), .durdur_o(durdur_a)
    );

    sifreleme_denetleyici #(.ISLEM_GECIKMESI(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n_b), .istek_gecerli_i(gecerli_b), .istek_hazir_o(hazir_b),
        .istek_kontrol_i(kod_b), .istek_deger1_i(d1_b), .istek_deger2_i(d2_b), .istek_hedef_i(hedef_b),
        .birim_kontrol_o(bk_b), .birim_deger1_o(bd1_b), .birim_deger2_o(bd2_b), .birim_sonuc_i(bsonuc_b),
        .yanit_gecerli_o(ygec_b), .yanit_hazir_i(yhazir_b), .yanit_sonuc_o(ysonuc_b),
        .yanit_hedef_o(yhedef_b), .yanit_hata_o(yhata_b), .temizle_i(temizle_b), .durdur_o(durdur_b)
    );

    task automatic check(input string ad, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", ad, act, exp);
        end
    endtask

    task automatic surucu_a(input logic [2:0] k, input logic [31:0] x, input logic [31:0] y, input logic [4:0] h);
        gecerli_a = 1'b1;
        kod_a = k;
        d1_a = x;
        d2_a = y;
        hedef_a = h;
    endtask

    // Issue on b and stop at the negedge right after the push edge (accept + 4).
    task automatic istek_b(input logic [2:0] k, input logic [31:0] x, input logic [31:0] y, input logic [4:0] h);
        @(negedge clk);
        gecerli_b = 1'b1;
        kod_b = k;
        d1_b = x;
        d2_b = y;
        hedef_b = h;
        @(posedge clk);
        #1 gecerli_b = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  kod;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  hedef;
        logic [31:0] sonuc;
        logic        hata;
    } vek_t;

    vek_t vek [11];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic goruldu;
        vek[0]  = '{SIFRELEME_CNTP,  32'h0000_00FF, 32'h0,         5'd7,  32'd8,          1'b0};
        vek[1]  = '{SIFRELEME_HMDST, 32'hFFFF_0000, 32'h0,         5'd1,  32'd16,         1'b0};
        vek[2]  = '{SIFRELEME_RVRS,  32'h0000_0001, 32'h0,         5'd2,  32'h8000_0000,  1'b0};
        vek[3]  = '{3'b111,          32'h1234_5678, 32'h9ABC_DEF0, 5'd9,  32'd0,          1'b1};
        vek[4]  = '{SIFRELEME_CNTP,  32'h0,         32'h0,         5'd10, 32'd0,          1'b0};
        vek[5]  = '{SIFRELEME_PKG,   32'h1234_ABCD, 32'h0000_5678, 5'd11, 32'h5678_ABCD,  1'b0};
        vek[6]  = '{SIFRELEME_SLADD, 32'd3,         32'd4,         5'd12, 32'd10,         1'b0};
        vek[7]  = '{SIFRELEME_CNTZ,  32'h0000_0080, 32'h0,         5'd13, 32'd7,          1'b0};
        vek[8]  = '{SIFRELEME_CNTZ,  32'h0,         32'h0,         5'd14, 32'd32,         1'b0};
        vek[9]  = '{3'b110,          32'hFFFF_FFFF, 32'h0,         5'd15, 32'd0,          1'b1};
        vek[10] = '{SIFRELEME_CNTP,  32'hFFFF_FFFF, 32'h0,         5'd31, 32'd32,         1'b0};

        rst_n_a = 1'b0; gecerli_a = 1'b0; yhazir_a = 1'b0; temizle_a = 1'b0;
        kod_a = 3'd0; d1_a = 32'd0; d2_a = 32'd0; hedef_a = 5'd0;
        rst_n_b = 1'b0; gecerli_b = 1'b0; yhazir_b = 1'b0; temizle_b = 1'b0;
        kod_b = 3'd0; d1_b = 32'd0; d2_b = 32'd0; hedef_b = 5'd0;

        #12;
        check("reset_hazir", 32'(hazir_a), 32'd1);
        check("reset_ygec", 32'(ygec_a), 32'd0);
        check("reset_sonuc", ysonuc_a, 32'd0);
        check("reset_hedef", 32'(yhedef_a), 32'd0);
        check("reset_hata", 32'(yhata_a), 32'd0);
        check("reset_durdur", 32'(durdur_a), 32'd0);
        check("reset_birim", bd1_a, 32'd0);
        @(negedge clk);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Table vectors, one request at a time with the response drained immediately
        yhazir_a = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check($sformatf("vek%0d_hazir_once", i), 32'(hazir_a), 32'd1);
            check($sformatf("vek%0d_bos_once", i), 32'(ygec_a), 32'd0);
            surucu_a(vek[i].kod, vek[i].d1, vek[i].d2, vek[i].hedef);
            @(posedge clk);
            #1 gecerli_a = 1'b0;
            @(negedge clk);
            check($sformatf("vek%0d_hazir_mesgul", i), 32'(hazir_a), 32'd0);
            check($sformatf("vek%0d_ygec_erken", i), 32'(ygec_a), 32'd0);
            check($sformatf("vek%0d_birim_kod", i), 32'(bk_a), 32'(vek[i].kod));
            @(negedge clk);
            check($sformatf("vek%0d_ygec", i), 32'(ygec_a), 32'd1);
            check($sformatf("vek%0d_sonuc", i), ysonuc_a, vek[i].sonuc);
            check($sformatf("vek%0d_hedef", i), 32'(yhedef_a), 32'(vek[i].hedef));
            check($sformatf("vek%0d_hata", i), 32'(yhata_a), 32'(vek[i].hata));
            check($sformatf("vek%0d_hazir_geri", i), 32'(hazir_a), 32'd1);
        end

        // Back-pressure: two results buffered, third request stalls until a pop
        @(negedge clk);
        yhazir_a = 1'b0;
        surucu_a(SIFRELEME_HMDST, 32'hFFFF_0000, 32'h0, 5'd1);
        @(posedge clk);
        #1 gecerli_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_ilk_ygec", 32'(ygec_a), 32'd1);
        check("bp_ilk_sonuc", ysonuc_a, 32'd16);
        check("bp_hazir_bir", 32'(hazir_a), 32'd1);
        surucu_a(SIFRELEME_RVRS, 32'h0000_0001, 32'h0, 5'd2);
        @(posedge clk);
        #1 gecerli_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_dolu_hazir", 32'(hazir_a), 32'd0);
        surucu_a(SIFRELEME_CNTP, 32'h0000_000F, 32'h0, 5'd3);
        #1;
        check("bp_durdur", 32'(durdur_a), 32'd1);
        check("bp_bas_sabit", ysonuc_a, 32'd16);
        repeat (2) @(negedge clk);
        check("bp_durdur_surer", 32'(durdur_a), 32'd1);
        check("bp_bas_hedef", 32'(yhedef_a), 32'd1);
        yhazir_a = 1'b1;
        @(posedge clk);
        #1 yhazir_a = 1'b0;
        @(negedge clk);
        check("bp_sira_sonuc", ysonuc_a, 32'h8000_0000);
        check("bp_sira_hedef", 32'(yhedef_a), 32'd2);
        check("bp_durdur_biter", 32'(durdur_a), 32'd0);
        @(posedge clk);
        #1 gecerli_a = 1'b0;
        @(negedge clk);
        yhazir_a = 1'b1;
        @(negedge clk);
        check("pp_ygec", 32'(ygec_a), 32'd1);
        check("pp_yeni_sonuc", ysonuc_a, 32'd4);
        check("pp_yeni_hedef", 32'(yhedef_a), 32'd3);
        @(negedge clk);
        check("pp_tek_kayit", 32'(ygec_a), 32'd0);
        yhazir_a = 1'b0;

        // Flush during HESAPLA with one buffered entry (ISLEM_GECIKMESI = 4)
        @(negedge clk);
        gecerli_b = 1'b1; kod_b = SIFRELEME_CNTP; d1_b = 32'h3; d2_b = 32'h0; hedef_b = 5'd4;
        @(posedge clk);
        #1 gecerli_b = 1'b0;
        repeat (4) @(negedge clk);
        check("g4_erken", 32'(ygec_b), 32'd0);
        @(negedge clk);
        check("g4_ygec", 32'(ygec_b), 32'd1);
        check("g4_sonuc", ysonuc_b, 32'd2);
        check("g4_hedef", 32'(yhedef_b), 32'd4);
        gecerli_b = 1'b1; kod_b = SIFRELEME_RVRS; d1_b = 32'h2; hedef_b = 5'd5;
        @(posedge clk);
        #1 gecerli_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("tem_oncesi_hazir", 32'(hazir_b), 32'd0);
        temizle_b = 1'b1;
        @(posedge clk);
        #1 temizle_b = 1'b0;
        @(negedge clk);
        check("tem_ygec", 32'(ygec_b), 32'd0);
        check("tem_hazir", 32'(hazir_b), 32'd1);
        check("tem_birim_kod", 32'(bk_b), 32'(SIFRELEME_RVRS));
        check("tem_birim_deger", bd1_b, 32'h2);
        goruldu = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ygec_b) goruldu = 1'b1;
        end
        check("tem_yanit_yok", 32'(goruldu), 32'd0);

        // Async reset with a full buffer
        istek_b(3'b111, 32'h5, 32'h0, 5'd6);
        istek_b(SIFRELEME_CNTP, 32'h7, 32'h0, 5'd8);
        check("dolu_hazir", 32'(hazir_b), 32'd0);
        check("dolu_bas_hata", 32'(yhata_b), 32'd1);
        @(posedge clk);
        #3 rst_n_b = 1'b0;
        #1;
        check("rst_dolu_ygec", 32'(ygec_b), 32'd0);
        check("rst_dolu_sonuc", ysonuc_b, 32'd0);
        check("rst_dolu_hedef", 32'(yhedef_b), 32'd0);
        check("rst_dolu_hata", 32'(yhata_b), 32'd0);
        check("rst_dolu_hazir", 32'(hazir_b), 32'd1);
        check("rst_dolu_birim", bd1_b, 32'd0);
        @(negedge clk);
        rst_n_b = 1'b1;

        // Async reset mid-HESAPLA
        @(negedge clk);
        gecerli_b = 1'b1; kod_b = SIFRELEME_CNTP; d1_b = 32'hFF; hedef_b = 5'd9;
        @(posedge clk);
        #1 gecerli_b = 1'b0;
        @(posedge clk);
        #3 rst_n_b = 1'b0;
        #1;
        check("rst_hes_hazir", 32'(hazir_b), 32'd1);
        check("rst_hes_birim", bd1_b, 32'd0);
        check("rst_hes_durdur", 32'(durdur_b), 32'd0);
        @(negedge clk);
        rst_n_b = 1'b1;
        goruldu = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ygec_b) goruldu = 1'b1;
        end
        check("rst_hes_yanit_yok", 32'(goruldu), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sifreleme_denetleyici.md
# sifreleme_denetleyici

Multi-cycle issue/response controller for the X-extension encryption instructions in the execute stage. It is the requester side of the operation interface of the combinational bit-manipulation unit. It accepts one instruction from the pipeline over a valid/ready handshake and drives the control code and operands to the unit from registers. After a fixed settle time it samples the unit's result and returns it through a 2-entry response buffer to writeback, stalling the pipeline while it cannot accept work.

## Interface
- ISLEM_GECIKMESI, 1: cycles operands are held before the result is sampled; legal range 1..15.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- istek_gecerli_i  in  1  request valid.
- istek_hazir_o  out  1  request ready.
- istek_kontrol_i  in  3  operation code (`SIFRELEME_*` values).
- istek_deger1_i / istek_deger2_i  in  32 each  operands.
- istek_hedef_i  in  5  destination register index.
- birim_kontrol_o  out  3  registered code to the unit.
- birim_deger1_o / birim_deger2_o  out  32 each  registered operands to the unit.
- birim_sonuc_i  in  32  unit result (combinational from birim_*_o).
- yanit_gecerli_o  out  1  response valid.
- yanit_hazir_i  in  1  response ready.
- yanit_sonuc_o  out  32  result.
- yanit_hedef_o  out  5  destination register index.
- yanit_hata_o  out  1  code matched no `SIFRELEME_*` constant.
- temizle_i  in  1  synchronous pipeline flush.
- durdur_o  out  1  stall request: istek_gecerli_i && !istek_hazir_o.

## Operation
- FSM states:
  - BOS (idle).
  - HESAPLA (operands driven, countdown running).
- BOS:
  - istek_hazir_o = (kayit_sayisi < 2).
  - On accept (gecerli && hazir): register kontrol, deger1, deger2, hedef and hata; load counter with ISLEM_GECIKMESI; go to HESAPLA.
- HESAPLA:
  - istek_hazir_o = 0.
  - The counter decrements each cycle.
  - When the counter equals 1: push {birim_sonuc_i, hedef, hata} into the buffer and return to BOS.
- Only one request is ever in flight. The accept condition guarantees buffer room at push time, so no overflow path exists.
- Buffer: 2-entry FIFO with 1-bit read/write pointers and a 2-bit count.
  - yanit_* outputs always show the head entry.
  - yanit_gecerli_o = (count != 0).
  - Pop on yanit_gecerli_o && yanit_hazir_i.
  - Push and pop on the same edge: count unchanged, both pointers advance.
- Illegal code (any value other than the six `SIFRELEME_*` constants): still executed. The result is whatever the unit returns (0), with yanit_hata_o = 1.
- temizle_i has priority over accept, push and pop on the same edge:
  - FSM goes to BOS.
  - The in-flight result is discarded.
  - FIFO count and pointers are cleared.
  - birim_*_o keep their values.
- Reset, including mid-operation:
  - FSM = BOS; counter, pointers and count = 0.
  - birim_*_o = 0; buffer contents = 0.
  - Resulting outputs: istek_hazir_o = 1, yanit_gecerli_o = 0, yanit_sonuc_o = 0, yanit_hedef_o = 0, yanit_hata_o = 0, durdur_o = istek_gecerli_i && 0 = 0.

## Timing
- Accept at edge T → birim_*_o valid from T+ε.
- Result sampled at edge T+ISLEM_GECIKMESI → yanit_gecerli_o high in the following cycle (if the buffer was empty).
- istek_hazir_o returns high the cycle after the push edge.
- Throughput: one request per ISLEM_GECIKMESI+1 cycles.
- Combinational paths:
  - istek_hazir_o and durdur_o depend only on registered state and istek_gecerli_i.
  - No combinational path from yanit_hazir_i to istek_hazir_o.
- Response outputs are stable while yanit_gecerli_o && !yanit_hazir_i.

## Structure
- Shared include tanimlamalar.vh holds:
  - the `SIFRELEME_*` codes (already present);
  - new FSM encodings `SIFDEN_BOS` = 1'b0 and `SIFDEN_HESAPLA` = 1'b1;
  - `SIFDEN_FIFO_DERINLIK` = 2.
- One sub-module: yanit_fifo. It is a 2-entry, 38-bit-wide FIFO (sonuc, hedef, hata) with push, pop, clear and asynchronous active-low reset.
- The combinational unit is instantiated beside this block by the execute stage, not inside it.

## Test plan
- Reset released, ISLEM_GECIKMESI=1:
  - CNTP request, deger1=0x0000_00FF, hedef=7, accepted at T → yanit_gecerli_o at T+1 cycle, sonuc=8, hedef=7, hata=0.
  - istek_hazir_o low for exactly one cycle.
- Back-pressure:
  - yanit_hazir_i held 0; issue HMDST (0xFFFF_0000, 0x0) then RVRS (0x0000_0001) → results 16 and 0x8000_0000.
  - Third request sees istek_hazir_o=0 and durdur_o=1 until the first pop.
  - Pops return in order.
- Simultaneous push and pop with the buffer holding one entry → count stays 1; next head is the new result.
- Illegal code 3'b111 → sonuc=0, hata=1; the following legal request reports hata=0.
- temizle_i asserted during HESAPLA with one buffered entry, ISLEM_GECIKMESI=4:
  - next cycle yanit_gecerli_o=0 and istek_hazir_o=1;
  - no response ever appears for the flushed request.
- rst_ni pulsed low asynchronously mid-HESAPLA and with a full buffer → all outputs return to their reset values immediately; no stale response after release.
